apb_timer: RTL

- APB responder peripheral: 64-bit free-running machine timer (mtime), 64-bit compare (mtimecmp), prescaler and level interrupt output.
- Sits behind the APB bus decoder beside the sram, sys_sram and uart responders, and answers CPU-initiated transfers.
- Inserts a programmable number of wait states.
- Reports errors for unmapped or misaligned accesses on perr.

---
 rtl/apb_timer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_timer.sv
// APB machine timer: 64-bit mtime/mtimecmp with prescaler, level interrupt,
// programmable wait states and error responses for unmapped/misaligned access.
module apb_timer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rts,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pdata,
  output logic [DATA_WIDTH-1:0] prdata,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [3:0]            pstb,
  output logic                  pready,
  output logic                  perr,
  output logic                  irq,
  output logic [1:0]            dbg_state
);

  // Handshake: a transfer is accepted by psel with penable low; once the
  // access phase starts the bus holds psel/penable/paddr/pwrite/pdata/pstb
  // stable until the single cycle where pready=1, which completes it.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        irq_q, irq_d;

  logic        access_cyc;
  logic        done;
  logic        addr_err;
  logic        rd_hit;
  logic        wr_hit;
  logic [2:0]  reg_idx;
  logic        match;
  logic [31:0] rdata;
  logic        unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign unused_addr = ^paddr[ADDR_WIDTH-1:5];
  assign reg_idx     = paddr[4:2];
  assign addr_err    = (paddr[1:0] != 2'b00) || (paddr[4:3] == 2'b11);
  assign match       = (mtime_q >= cmp_q);

  // The FSM lags the bus by one cycle, so the first penable cycle is seen in
  // SETUP (or IDLE on a protocol violation) and already counts as a wait.
  assign access_cyc = !rts && ((state_q == S_ACCESS) ||
                               (state_q == S_SETUP && psel && penable) ||
                               (state_q == S_IDLE  && psel && penable));
  assign done   = access_cyc && (wait_q == WAIT_LAST);
  assign rd_hit = done && !pwrite && !addr_err;
  assign wr_hit = done &&  pwrite && !addr_err;

  assign pready    = done;
  assign perr      = done && addr_err;
  assign irq       = irq_q;
  assign dbg_state = state_q;

  always_comb begin
    rdata = '0;
    case (reg_idx)
      3'd0:    rdata = mtime_q[31:0];
      3'd1:    rdata = shadow_q;
      3'd2:    rdata = cmp_q[31:0];
      3'd3:    rdata = cmp_q[63:32];
      3'd4:    rdata = {16'h0, presc_q, 6'h0, ie_q, en_q};
      3'd5:    rdata = {31'h0, match};
      default: rdata = '0;
    endcase
  end

  assign prdata = rd_hit ? rdata : '0;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (psel && penable) begin
          state_d = done ? S_IDLE : S_ACCESS;
          wait_d  = done ? 3'd0 : wait_q + 3'd1;
        end else if (psel) begin
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (penable) begin
          state_d = done ? S_IDLE : S_ACCESS;
          wait_d  = done ? 3'd0 : wait_q + 3'd1;
        end
      end
      S_ACCESS: begin
        state_d = done ? S_IDLE : S_ACCESS;
        wait_d  = done ? 3'd0 : wait_q + 3'd1;
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = 3'd0;
      end
    endcase
  end

  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    shadow_d = shadow_q;
    presc_d  = presc_q;
    pcnt_d   = 8'd0;
    en_d     = en_q;
    ie_d     = ie_q;

    // >= keeps the counter bounded if PRESC is lowered below the live count.
    if (en_q) begin
      if (pcnt_q >= presc_q) begin
        pcnt_d  = 8'd0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        pcnt_d = pcnt_q + 8'd1;
      end
    end

    if (rd_hit && reg_idx == 3'd0) shadow_d = mtime_q[63:32];

    // A bus write to mtime overrides this cycle's increment and restarts the prescaler.
    if (wr_hit) begin
      case (reg_idx)
        3'd0: begin
          mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], pdata, pstb)};
          if (|pstb) pcnt_d = 8'd0;
        end
        3'd1: begin
          mtime_d = {merge(mtime_q[63:32], pdata, pstb), mtime_q[31:0]};
          if (|pstb) pcnt_d = 8'd0;
        end
        3'd2: cmp_d = {cmp_q[63:32], merge(cmp_q[31:0], pdata, pstb)};
        3'd3: cmp_d = {merge(cmp_q[63:32], pdata, pstb), cmp_q[31:0]};
        3'd4: begin
          if (pstb[0]) begin
            en_d = pdata[0];
            ie_d = pdata[1];
          end
          if (pstb[1]) presc_d = pdata[15:8];
        end
        default: ;
      endcase
    end

    irq_d = ie_q && match;
  end

  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      state_q  <= S_IDLE;
      wait_q   <= 3'd0;
      mtime_q  <= 64'd0;
      cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_q <= 32'd0;
      presc_q  <= 8'd0;
      pcnt_q   <= 8'd0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      irq_q    <= irq_d;
    end
  end

endmodule
